// File: rtl/redundant_tx_scheduler.sv
// TX sequencer for the redundant link: captures one frame into an external BRAM,
// then replays it R times with a copy-ID byte spliced in and an idle gap after each copy.
module redundant_tx_scheduler #(
  parameter int R         = 5,
  parameter int WHEREISID = 0,
  parameter int IFG       = 12,
  parameter int ADDR_W    = 12,
  parameter int MAX_LEN   = 1500
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxd,
  input  logic              rxen,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic              wea,
  output logic [ADDR_W-1:0] addrb,
  input  logic [7:0]        doutb,
  output logic [7:0]        txd,
  output logic              txen,
  output logic [3:0]        copy_id,
  output logic              busy,
  output logic              drop,
  output logic              overflow
);
  // One extra bit so a count of exactly MAX_LEN (which may equal 2^ADDR_W) fits.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LW      = CW'(WHEREISID);
  localparam logic [CW-1:0] LMAX    = CW'(MAX_LEN);
  localparam logic [CW-1:0] LIFG_M1 = CW'(IFG - 1);
  localparam logic [3:0]    LR      = 4'(R);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND, GAP} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt, r_len, r_k;
  logic [3:0]        r_copy;
  logic              r_ign, r_ovf, r_v, r_isid;
  logic              r_wea, r_drop, r_overflow;
  logic [ADDR_W-1:0] r_addra;
  logic [7:0]        r_dina;
  logic              w_accept, w_short, w_busy;

  assign w_busy  = (r_state == SEND) || (r_state == GAP);
  assign w_short = (r_cnt == '0) || (r_cnt < LW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE:    if (rxen && !r_ign) begin w_next = CAPTURE; w_accept = 1'b1; end
      CAPTURE: if (!rxen) w_next = w_short ? IDLE : SEND;
      SEND:    if (r_k == r_len) w_next = GAP;
      GAP:     if (r_k == LIFG_M1) w_next = (r_copy == LR) ? IDLE : SEND;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_k        <= '0;
      r_copy     <= '0;
      r_ign      <= 1'b0;
      r_ovf      <= 1'b0;
      r_v        <= 1'b0;
      r_isid     <= 1'b0;
      r_wea      <= 1'b0;
      r_drop     <= 1'b0;
      r_overflow <= 1'b0;
      r_addra    <= '0;
      r_dina     <= '0;
    end else begin
      r_wea      <= 1'b0;
      r_drop     <= 1'b0;
      r_overflow <= 1'b0;
      // A frame that starts while busy stays ignored until its rxen drops,
      // even if the scheduler goes idle mid-frame.
      r_ign      <= rxen && (r_ign || w_busy);
      if (rxen && w_busy && !r_ign) r_drop <= 1'b1;
      // Read pipeline: one stage aligns the ID select with BRAM read latency.
      r_v        <= (r_state == SEND);
      r_isid     <= (r_state == SEND) && (r_k == LW);
      case (r_state)
        IDLE: if (w_accept) begin
          r_wea   <= 1'b1;
          r_addra <= '0;
          r_dina  <= rxd;
          r_cnt   <= CW'(1);
          r_ovf   <= 1'b0;
        end
        CAPTURE: if (rxen) begin
          if (r_cnt < LMAX) begin
            r_wea   <= 1'b1;
            r_addra <= ADDR_W'(r_cnt);
            r_dina  <= rxd;
            r_cnt   <= r_cnt + CW'(1);
          end else r_ovf <= 1'b1;
        end else begin
          r_len      <= r_cnt;
          r_overflow <= r_ovf;
          r_k        <= '0;
          if (w_short) r_drop <= 1'b1;
          else         r_copy <= 4'd1;
        end
        SEND: r_k <= (r_k == r_len) ? '0 : r_k + CW'(1);
        GAP: begin
          if (r_k == LIFG_M1) begin
            r_k    <= '0;
            r_copy <= (r_copy == LR) ? 4'd0 : r_copy + 4'd1;
          end else r_k <= r_k + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Byte k of a copy maps to address k before the ID slot and k-1 after it;
  // the ID slot itself re-reads a valid address that is simply not used.
  assign addrb = (r_state != SEND) ? '0 :
                 (r_k != '0 && r_k >= LW) ? ADDR_W'(r_k - CW'(1)) : ADDR_W'(r_k);

  assign addra    = r_addra;
  assign dina     = r_dina;
  assign wea      = r_wea;
  assign txen     = r_v;
  assign txd      = !r_v ? 8'h00 : (r_isid ? {4'h0, r_copy} : doutb);
  assign copy_id  = r_copy;
  assign busy     = w_busy;
  assign drop     = r_drop;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_redundant_tx_scheduler.sv
// Scoreboard bench: instance A uses default parameters, instance B uses
// WHEREISID=2, R=3, IFG=4, MAX_LEN=16 to reach the ID-offset and overflow cases.
module tb_redundant_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rxd_a = '0, dina_a, doutb_a = '0, txd_a;
  logic        rxen_a = 1'b0, wea_a, txen_a, busy_a, drop_a, overflow_a;
  logic [11:0] addra_a, addrb_a;
  logic [3:0]  copy_id_a;

  logic [7:0]  rxd_b = '0, dina_b, doutb_b = '0, txd_b;
  logic        rxen_b = 1'b0, wea_b, txen_b, busy_b, drop_b, overflow_b;
  logic [4:0]  addra_b, addrb_b;
  logic [3:0]  copy_id_b;

  redundant_tx_scheduler u_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rxen(rxen_a), .addra(addra_a), .dina(dina_a),
    .wea(wea_a), .addrb(addrb_a), .doutb(doutb_a), .txd(txd_a), .txen(txen_a),
    .copy_id(copy_id_a), .busy(busy_a), .drop(drop_a), .overflow(overflow_a));

  redundant_tx_scheduler #(.R(3), .WHEREISID(2), .IFG(4), .ADDR_W(5), .MAX_LEN(16)) u_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rxen(rxen_b), .addra(addra_b), .dina(dina_b),
    .wea(wea_b), .addrb(addrb_b), .doutb(doutb_b), .txd(txd_b), .txen(txen_b),
    .copy_id(copy_id_b), .busy(busy_b), .drop(drop_b), .overflow(overflow_b));

  logic [7:0] mem_a [0:4095];
  logic [7:0] mem_b [0:31];
  always @(posedge clk) begin
    if (wea_a) mem_a[addra_a] <= dina_a;
    doutb_a <= mem_a[addrb_a];
    if (wea_b) mem_b[addra_b] <= dina_b;
    doutb_b <= mem_b[addrb_b];
  end

  int n_vec = 0, n_err = 0;
  logic [11:0] qa[$], qb[$];
  int bqa[$], bqb[$];
  int drops_a = 0, drops_b = 0, ovf_b = 0;
  logic hi_wr_b = 1'b0;
  logic [7:0] fr [0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // Monitor A: tx stream, inter-copy gap length, busy duration, pulses.
  logic ta_prev = 0, ba_prev = 0;
  int la_run = 0, ba_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      ta_prev = 0; ba_prev = 0; la_run = 0; ba_cnt = 0;
    end else begin
      if (txen_a) begin
        if (!ta_prev && copy_id_a != 4'd1) chk("a_gap_len", la_run, 12);
        if (qa.size() == 0) fail_now("a_tx_extra", {copy_id_a, txd_a});
        else chk("a_tx", {copy_id_a, txd_a}, qa.pop_front());
        la_run = 0;
      end else la_run++;
      ta_prev = txen_a;
      if (busy_a) ba_cnt++;
      else if (ba_prev) begin
        if (bqa.size() == 0) fail_now("a_busy_extra", ba_cnt);
        else chk("a_busy_cycles", ba_cnt, bqa.pop_front());
        ba_cnt = 0;
      end
      ba_prev = busy_a;
      if (drop_a) drops_a++;
    end
  end

  logic tb_prev = 0, bb_prev = 0;
  int lb_run = 0, bb_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      tb_prev = 0; bb_prev = 0; lb_run = 0; bb_cnt = 0;
    end else begin
      if (txen_b) begin
        if (!tb_prev && copy_id_b != 4'd1) chk("b_gap_len", lb_run, 4);
        if (qb.size() == 0) fail_now("b_tx_extra", {copy_id_b, txd_b});
        else chk("b_tx", {copy_id_b, txd_b}, qb.pop_front());
        lb_run = 0;
      end else lb_run++;
      tb_prev = txen_b;
      if (busy_b) bb_cnt++;
      else if (bb_prev) begin
        if (bqb.size() == 0) fail_now("b_busy_extra", bb_cnt);
        else chk("b_busy_cycles", bb_cnt, bqb.pop_front());
        bb_cnt = 0;
      end
      bb_prev = busy_b;
      if (drop_b) drops_b++;
      if (overflow_b) ovf_b++;
      if (wea_b && addra_b >= 5'd16) hi_wr_b = 1'b1;
    end
  end

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fr[i] = base + 8'(i);
  endtask

  // Expected replicated stream for the current contents of fr.
  task automatic expect_frame(input bit which, input int n);
    int r, w, ifg, maxl, len;
    logic [7:0] by;
    r = which ? 3 : 5; w = which ? 2 : 0; ifg = which ? 4 : 12; maxl = which ? 16 : 1500;
    len = (n < maxl) ? n : maxl;
    for (int c = 1; c <= r; c++)
      for (int k = 0; k <= len; k++) begin
        by = (k < w) ? fr[k] : (k == w) ? 8'(c) : fr[k-1];
        if (which) qb.push_back({4'(c), by}); else qa.push_back({4'(c), by});
      end
    if (which) bqb.push_back(r * (len + 1 + ifg)); else bqa.push_back(r * (len + 1 + ifg));
  endtask

  // Call on a falling edge; returns on the falling edge where rxen was lowered.
  task automatic drive(input bit which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) begin rxd_b = fr[i]; rxen_b = 1'b1; end
      else       begin rxd_a = fr[i]; rxen_a = 1'b1; end
      @(negedge clk);
    end
    rxen_a = 1'b0; rxen_b = 1'b0; rxd_a = '0; rxd_b = '0;
  endtask

  task automatic wait_idle(input bit which, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (which ? (qb.size() == 0 && bqb.size() == 0 && !busy_b)
                : (qa.size() == 0 && bqa.size() == 0 && !busy_a)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(which ? "b_idle_timeout" : "a_idle_timeout", ok, 1);
  endtask

  initial begin
    int d0, n3;
    logic ok, seen, bz;
    repeat (3) @(negedge clk);
    chk("a_reset_outs", {txen_a, busy_a, wea_a, drop_a, overflow_a, copy_id_a, txd_a}, 0);
    chk("a_reset_addr", {addra_a, addrb_a}, 0);
    chk("b_reset_outs", {txen_b, busy_b, wea_b, drop_b, overflow_b, copy_id_b, txd_b, addra_b, addrb_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 8-byte frame, ID at offset 0, five copies.
    fill(8'h10, 8); expect_frame(0, 8); drive(0, 8); wait_idle(0, 400);
    chk("a_no_drop", drops_a, 0);

    // ID at offset 2 and first-txen latency.
    fr[0] = 8'hAA; fr[1] = 8'hBB; fr[2] = 8'hCC; fr[3] = 8'hDD;
    expect_frame(1, 4); drive(1, 4);
    @(negedge clk); chk("b_txen_lat1", txen_b, 0);
    @(negedge clk); chk("b_txen_lat2", txen_b, 1);
    wait_idle(1, 200);

    // Frame arriving during copy 3 is dropped; the running copies continue intact.
    fill(8'h11, 5); expect_frame(1, 5); drive(1, 5);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (copy_id_b == 4'd3) begin ok = 1'b1; break; end
    end
    chk("b_reach_copy3", ok, 1);
    d0 = drops_b;
    fill(8'h97, 3); drive(1, 3); wait_idle(1, 200);
    chk("b_drop_busy", drops_b, d0 + 1);
    fill(8'h01, 6); expect_frame(1, 6); drive(1, 6); wait_idle(1, 200);

    // Frame rising in the final gap cycle is still rejected.
    fill(8'h71, 3); expect_frame(1, 3); drive(1, 3);
    seen = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (copy_id_b == 4'd3 && txen_b) seen = 1'b1;
      else if (seen && !txen_b) begin ok = 1'b1; break; end
    end
    chk("b_reach_gap", ok, 1);
    repeat (2) @(negedge clk);
    chk("b_busy_last_gap", busy_b, 1);
    d0 = drops_b;
    fill(8'h61, 3); drive(1, 3); wait_idle(1, 200);
    chk("b_drop_edge", drops_b, d0 + 1);

    // Single-byte frame is shorter than the ID offset.
    d0 = drops_b; bz = 1'b0;
    fr[0] = 8'h5A; drive(1, 1);
    repeat (10) begin @(negedge clk); if (busy_b) bz = 1'b1; end
    chk("b_short_drop", drops_b, d0 + 1);
    chk("b_short_nobusy", bz, 0);

    // 20 bytes into a 16-byte store.
    d0 = ovf_b;
    fill(8'h80, 20); expect_frame(1, 20); drive(1, 20); wait_idle(1, 300);
    chk("b_overflow", ovf_b, d0 + 1);
    chk("b_no_high_write", hi_wr_b, 0);

    // Reset in the 3rd byte of copy 2, then a fresh frame from copy 1.
    fill(8'h30, 8); expect_frame(0, 8); drive(0, 8);
    n3 = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (txen_a && copy_id_a == 4'd2) n3++;
      if (n3 == 3) begin ok = 1'b1; break; end
    end
    chk("a_reach_c2b3", ok, 1);
    #1 rst = 1'b1;
    qa.delete(); bqa.delete();
    #1 chk("a_async_rst", {txen_a, busy_a, copy_id_a}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("a_post_rst_idle", {txen_a, busy_a, copy_id_a}, 0);
    fill(8'h40, 8); expect_frame(0, 8); drive(0, 8); wait_idle(0, 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
